// File: rtl/imem_loader.sv
// UART-driven program loader for the MIPS instruction memory.
// Holds the pipeline while loading and answers each command with ACK/NAK.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_ADDR_WIDTH = 8,
  parameter logic [7:0] ACK_BYTE = 8'h06,
  parameter logic [7:0] NAK_BYTE = 8'h15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       tx_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]      imem_wdata,
  output logic                       cpu_run,
  output logic                       busy,
  output logic [IMEM_ADDR_WIDTH:0]   words_loaded
);

  localparam int AW = IMEM_ADDR_WIDTH;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, GET_CNT, GET_B0, GET_B1,
    GET_B2, GET_B3, WRITE, RESP
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] idx, cnt, idx_inc;
  logic [DATA_WIDTH-1:0] word;
  logic [7:0] resp;
  logic cnt_ok;

  assign idx_inc = idx + CW'(1);
  // N may equal the depth; only strictly larger counts are rejected
  assign cnt_ok = 32'(rx_data) <= (32'd1 << AW);

  assign tx_valid = (state == RESP);
  assign imem_we = (state == WRITE);
  assign busy = (state != IDLE);
  assign imem_addr = idx[AW-1:0];
  assign imem_wdata = word;

  always_comb begin
    state_nx = state;
    resp = ACK_BYTE;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            8'h4C: state_nx = GET_CNT;
            8'h52, 8'h48: state_nx = RESP;
            default: begin
              state_nx = RESP;
              resp = NAK_BYTE;
            end
          endcase
        end
      end
      GET_CNT: begin
        if (rx_valid) begin
          if (rx_data == 8'd0) begin
            state_nx = RESP;
          end else if (!cnt_ok) begin
            state_nx = RESP;
            resp = NAK_BYTE;
          end else begin
            state_nx = GET_B0;
          end
        end
      end
      GET_B0: if (rx_valid) state_nx = GET_B1;
      GET_B1: if (rx_valid) state_nx = GET_B2;
      GET_B2: if (rx_valid) state_nx = GET_B3;
      GET_B3: if (rx_valid) state_nx = WRITE;
      WRITE: begin
        if (idx_inc == cnt) state_nx = RESP;
        else if (rx_valid) state_nx = GET_B1;
        else state_nx = GET_B0;
      end
      RESP: if (tx_ready) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tx_data <= '0;
      cpu_run <= 1'b0;
      idx <= '0;
      cnt <= '0;
      word <= '0;
      words_loaded <= '0;
    end else begin
      state <= state_nx;
      if (state != RESP && state_nx == RESP) tx_data <= resp;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == 8'h52) cpu_run <= 1'b1;
            else if (rx_data == 8'h4C || rx_data == 8'h48) cpu_run <= 1'b0;
          end
        end
        GET_CNT: begin
          if (rx_valid) begin
            cnt <= CW'(rx_data);
            idx <= '0;
            if (rx_data == 8'd0) words_loaded <= '0;
          end
        end
        GET_B0: if (rx_valid) word[31:24] <= rx_data;
        GET_B1: if (rx_valid) word[23:16] <= rx_data;
        GET_B2: if (rx_valid) word[15:8] <= rx_data;
        GET_B3: if (rx_valid) word[7:0] <= rx_data;
        WRITE: begin
          idx <= idx_inc;
          // a byte arriving during the write pulse is the next word's MSB
          if (idx_inc == cnt) words_loaded <= cnt;
          else if (rx_valid) word[31:24] <= rx_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 16-word IMEM.
// Expected values are hand-computed constants.
module tb_imem_loader;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic tx_valid;
  logic imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic cpu_run;
  logic busy;
  logic [AW:0] words_loaded;

  int total = 0;
  int bad = 0;
  int base;
  logic [AW-1:0] la[$];
  logic [31:0] ld[$];
  logic [7:0] s1[8] = '{8'h20, 8'h01, 8'h00, 8'h0A,
                        8'h20, 8'h02, 8'h00, 8'h14};
  logic [31:0] wv;

  imem_loader #(
    .DATA_WIDTH(32),
    .IMEM_ADDR_WIDTH(AW),
    .ACK_BYTE(8'h06),
    .NAK_BYTE(8'h15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_run(cpu_run),
    .busy(busy),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we) begin
      la.push_back(imem_addr);
      ld.push_back(imem_wdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_resp(input logic [7:0] exp, input string tag);
    int n = 0;
    while (!tx_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(tx_valid), 64'd1);
    chk({tag, "_data"}, 64'(tx_data), 64'(exp));
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk({tag, "_drop"}, 64'(tx_valid), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_run", 64'(cpu_run), 64'd0);
    chk("rst_txv", 64'(tx_valid), 64'd0);
    chk("rst_txd", 64'(tx_data), 64'd0);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_wl", 64'(words_loaded), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;

    send(8'h52);
    chk("r_run", 64'(cpu_run), 64'd1);
    chk("r_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("r_hold", 64'(tx_valid), 64'd1);
    wait_resp(8'h06, "r_ack");

    send(8'h4C);
    send(8'h02);
    chk("l_run", 64'(cpu_run), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) begin
        chk("w0_we", 64'(imem_we), 64'd1);
        chk("w0_addr", 64'(imem_addr), 64'd0);
        chk("w0_data", 64'(imem_wdata), 64'h2001000A);
      end
      rx_data = s1[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("w1_we", 64'(imem_we), 64'd1);
    chk("w1_addr", 64'(imem_addr), 64'd1);
    chk("w1_data", 64'(imem_wdata), 64'h20020014);
    @(negedge clk);
    chk("ack_lat", 64'(tx_valid), 64'd1);
    chk("ack_we", 64'(imem_we), 64'd0);
    wait_resp(8'h06, "l2_ack");
    chk("l2_cnt", 64'(la.size()), 64'd2);
    chk("l2_a0", 64'(la[0]), 64'd0);
    chk("l2_d0", 64'(ld[0]), 64'h2001000A);
    chk("l2_a1", 64'(la[1]), 64'd1);
    chk("l2_d1", 64'(ld[1]), 64'h20020014);
    chk("l2_wl", 64'(words_loaded), 64'd2);
    chk("l2_run", 64'(cpu_run), 64'd0);

    send(8'h4C);
    send(8'h00);
    wait_resp(8'h06, "l0_ack");
    chk("l0_cnt", 64'(la.size()), 64'd2);
    chk("l0_wl", 64'(words_loaded), 64'd0);

    send(8'h4C);
    send(8'h11);
    wait_resp(8'h15, "l17_nak");
    repeat (2) @(negedge clk);
    chk("l17_cnt", 64'(la.size()), 64'd2);

    send(8'h52);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_v", 64'(tx_valid), 64'd1);
      chk("hold_d", 64'(tx_data), 64'h06);
      rx_data = 8'h48;
      rx_valid = (k == 1);
    end
    rx_valid = 1'b0;
    wait_resp(8'h06, "hold_ack");
    chk("drop_run", 64'(cpu_run), 64'd1);

    send(8'h3F);
    chk("unk_run", 64'(cpu_run), 64'd1);
    wait_resp(8'h15, "unk_nak");
    send(8'h48);
    chk("h_run", 64'(cpu_run), 64'd0);
    wait_resp(8'h06, "h_ack");

    base = la.size();
    send(8'h4C);
    send(8'h10);
    for (int w = 0; w < 16; w++) begin
      wv = {8'hC0, 8'(w), 8'hA5, 8'(w * 3)};
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        rx_data = wv[31 - 8 * b -: 8];
        rx_valid = 1'b1;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    wait_resp(8'h06, "l16_ack");
    chk("l16_cnt", 64'(la.size() - base), 64'd16);
    chk("l16_a7", 64'(la[base + 7]), 64'd7);
    chk("l16_d7", 64'(ld[base + 7]), 64'hC007A515);
    chk("l16_a15", 64'(la[base + 15]), 64'd15);
    chk("l16_d15", 64'(ld[base + 15]), 64'hC00FA52D);
    chk("l16_wl", 64'(words_loaded), 64'h10);

    base = la.size();
    send(8'h4C);
    send(8'h03);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    send(8'h66);
    reset = 1'b0;
    @(negedge clk);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_txv", 64'(tx_valid), 64'd0);
    chk("ar_we", 64'(imem_we), 64'd0);
    chk("ar_addr", 64'(imem_addr), 64'd0);
    chk("ar_wdata", 64'(imem_wdata), 64'd0);
    chk("ar_wl", 64'(words_loaded), 64'd0);
    chk("ar_cnt", 64'(la.size() - base), 64'd1);
    chk("ar_d0", 64'(ld[base]), 64'h11223344);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("ar_noresp", 64'(tx_valid), 64'd0);

    send(8'h4C);
    send(8'h01);
    send(8'h8C);
    send(8'h01);
    send(8'h00);
    send(8'h04);
    wait_resp(8'h06, "fr_ack");
    chk("fr_cnt", 64'(la.size() - base), 64'd2);
    chk("fr_a", 64'(la[base + 1]), 64'd0);
    chk("fr_d", 64'(ld[base + 1]), 64'h8C010004);
    chk("fr_wl", 64'(words_loaded), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
